// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/Funct, runs single-cycle ops or an iterative
// shift-add multiply, with valid/ready handshakes on both sides and a pipeline flush.
module alu_exec_unit #(
    parameter int XLEN   = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop,
    input  logic [3:0]      in_funct,
    input  logic            in_mext,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [3:0]      out_op,
    output logic [2:0]      out_funct,
    output logic            out_illegal
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic            w_accept;
    logic            w_isMul;
    logic            w_illegal;
    logic            w_lastIter;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_mulSum;

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [SHW-1:0]  r_cnt;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic [3:0]      r_op;
    logic [2:0]      r_funct;
    logic            r_illegal;

    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
        w_isMul   = 1'b0;
        case (in_aluop)
            2'b00: begin
                if (in_funct[2:0] == 3'b001) begin
                    w_op = OP_SLL;
                end
            end
            2'b01: begin
                w_op = OP_SUB;
            end
            2'b10: begin
                if (MUL_EN && in_mext) begin
                    w_op    = OP_MUL;
                    w_isMul = 1'b1;
                end else begin
                    case (in_funct)
                        4'b0000: w_op = OP_ADD;
                        4'b1000: w_op = OP_SUB;
                        4'b0111: w_op = OP_AND;
                        4'b0110: w_op = OP_OR;
                        default: w_illegal = 1'b1;
                    endcase
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_result = in_a + in_b;
        case (w_op)
            OP_SUB:  w_result = in_a - in_b;
            OP_SLL:  w_result = in_a << in_b[SHW-1:0];
            OP_AND:  w_result = in_a & in_b;
            OP_OR:   w_result = in_a | in_b;
            default: w_result = in_a + in_b;
        endcase
    end

    assign w_mulSum   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_lastIter = (r_cnt == SHW'(XLEN - 1));

    // A held result may be replaced in the same cycle the consumer takes it.
    assign in_ready  = !flush && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_nextState = w_isMul ? S_MUL : S_DONE;
                    end
                end
                S_MUL: begin
                    if (w_lastIter) begin
                        w_nextState = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            w_nextState = w_isMul ? S_MUL : S_DONE;
                        end else begin
                            w_nextState = S_IDLE;
                        end
                    end
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // MUL results land in r_result on the final iteration; other ops land at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_op      <= '0;
            r_funct   <= '0;
            r_illegal <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                r_op      <= w_op;
                r_funct   <= in_funct[2:0];
                r_illegal <= w_illegal;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_mcand   <= in_a;
                r_mplier  <= in_b;
                if (!w_isMul) begin
                    r_result <= w_result;
                    r_zero   <= (w_result == '0);
                end
            end else if (r_state == S_MUL) begin
                r_acc    <= w_mulSum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + SHW'(1);
                if (w_lastIter) begin
                    r_result <= w_mulSum;
                    r_zero   <= (w_mulSum == '0);
                end
            end
        end
    end

    assign out_result  = r_result;
    assign out_zero    = r_zero;
    assign out_op      = r_op;
    assign out_funct   = r_funct;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a negedge monitor scoreboards every accepted
// request against a reference model and compares it with the result handed out.
module tb_alu_exec_unit;

    localparam int XLEN = 64;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b1;
    logic            flush     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [1:0]      in_aluop  = '0;
    logic [3:0]      in_funct  = '0;
    logic            in_mext   = 1'b0;
    logic [XLEN-1:0] in_a      = '0;
    logic [XLEN-1:0] in_b      = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [3:0]      out_op;
    logic [2:0]      out_funct;
    logic            out_illegal;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
        logic [3:0]      op;
        logic [2:0]      funct;
        logic            illegal;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   busyReady;
    int   validCount;

    alu_exec_unit #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aluop   (in_aluop),
        .in_funct   (in_funct),
        .in_mext    (in_mext),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_op     (out_op),
        .out_funct  (out_funct),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] aluop, input logic [3:0] funct,
                                   input logic mext, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        exp_t e;
        e.op      = 4'b0010;
        e.res     = a + b;
        e.illegal = 1'b0;
        e.funct   = funct[2:0];
        case (aluop)
            2'b00: if (funct[2:0] == 3'b001) begin e.op = 4'b0111; e.res = a << b[5:0]; end
            2'b01: begin e.op = 4'b0110; e.res = a - b; end
            2'b10: begin
                if (mext) begin e.op = 4'b1000; e.res = a * b; end
                else if (funct == 4'b1000) begin e.op = 4'b0110; e.res = a - b; end
                else if (funct == 4'b0111) begin e.op = 4'b0000; e.res = a & b; end
                else if (funct == 4'b0110) begin e.op = 4'b0001; e.res = a | b; end
                else if (funct != 4'b0000) e.illegal = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] got,
                               input logic [XLEN-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] aluop, input logic [3:0] funct,
                                 input logic mext, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
        in_valid = 1'b1;
        in_aluop = aluop;
        in_funct = funct;
        in_mext  = mext;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and confirm its result appears one cycle later.
    task automatic runSingle(input string tag, input logic [1:0] aluop,
                             input logic [3:0] funct, input logic mext,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        applyStimulus(aluop, funct, mext, a, b);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        tick();
        idle();
        checkOutput({tag, "_latency"}, out_valid, 1);
    endtask

    task automatic runMul(input string tag, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b);
        applyStimulus(2'b10, 4'b0000, 1'b1, a, b);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        tick();
        idle();
        lat       = 1;
        busyReady = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busyReady++;
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, XLEN + 1);
        checkOutput({tag, "_busy_in_ready"}, busyReady, 0);
    endtask

    // Scoreboard: push on accept, pop on output handshake; flush and reset drop everything.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checkOutput("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    monExp = sb.pop_front();
                    checkOutput("result", out_result, monExp.res);
                    checkOutput("zero", out_zero, monExp.zero);
                    checkOutput("op", out_op, monExp.op);
                    checkOutput("funct", out_funct, monExp.funct);
                    checkOutput("illegal", out_illegal, monExp.illegal);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_aluop, in_funct, in_mext, in_a, in_b));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting alu_exec_unit bench");
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_zero", out_zero, 0);
        checkOutput("rst_out_op", out_op, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        tick();

        runSingle("sub", 2'b10, 4'b1000, 1'b0, 64'd5, 64'd7);
        checkOutput("sub_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("sub_op", out_op, 4'b0110);
        checkOutput("sub_zero", out_zero, 0);
        tick();

        runSingle("beq", 2'b01, 4'b0101, 1'b0, 64'h1234, 64'h1234);
        checkOutput("beq_result", out_result, 0);
        checkOutput("beq_zero", out_zero, 1);
        checkOutput("beq_funct", out_funct, 3'b101);
        tick();

        runSingle("sll", 2'b00, 4'b0001, 1'b0, 64'd1, 64'(XLEN + 3));
        checkOutput("sll_result", out_result, 64'd8);
        checkOutput("sll_op", out_op, 4'b0111);
        tick();

        runSingle("and", 2'b10, 4'b0111, 1'b0, 64'hF0F0, 64'hFF00);
        tick();
        runSingle("or", 2'b10, 4'b0110, 1'b0, 64'hF0F0, 64'h0F0F);
        tick();
        runSingle("addi_mext", 2'b00, 4'b0000, 1'b1, 64'd3, 64'd4);
        checkOutput("addi_mext_result", out_result, 64'd7);
        tick();

        runMul("mul_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        checkOutput("mul_max_result", out_result, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();
        runMul("mul_mix", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        tick();

        out_ready = 1'b0;
        applyStimulus(2'b10, 4'b0000, 1'b0, 64'd100, 64'd23);
        tick();
        applyStimulus(2'b10, 4'b0000, 1'b0, 64'd1, 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_result", out_result, 64'd123);
            checkOutput("hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("b2b_in_ready", in_ready, 1);
        tick();
        applyStimulus(2'b10, 4'b0000, 1'b0, 64'd2, 64'd2);
        checkOutput("b2b1_valid", out_valid, 1);
        checkOutput("b2b1_result", out_result, 64'd2);
        tick();
        applyStimulus(2'b10, 4'b0000, 1'b0, 64'd3, 64'd3);
        checkOutput("b2b2_valid", out_valid, 1);
        checkOutput("b2b2_result", out_result, 64'd4);
        tick();
        idle();
        checkOutput("b2b3_valid", out_valid, 1);
        checkOutput("b2b3_result", out_result, 64'd6);
        tick();

        out_ready = 1'b0;
        applyStimulus(2'b10, 4'b0110, 1'b0, 64'h0F, 64'hF0);
        tick();
        idle();
        checkOutput("flush_done_valid", out_valid, 1);
        flush = 1'b1;
        applyStimulus(2'b00, 4'b0000, 1'b0, 64'd9, 64'd9);
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        checkOutput("flush_drop_valid", out_valid, 0);
        tick();
        checkOutput("flush_no_accept", out_valid, 0);

        applyStimulus(2'b10, 4'b0000, 1'b1, 64'd5, 64'd6);
        tick();
        idle();
        repeat (9) tick();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_result", out_result, 0);
        checkOutput("midrst_illegal", out_illegal, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1);
        validCount = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) validCount++;
            tick();
        end
        checkOutput("midrst_never_valid", validCount, 0);

        applyStimulus(2'b10, 4'b0000, 1'b1, 64'd7, 64'd8);
        tick();
        idle();
        repeat (19) tick();
        flush = 1'b1;
        applyStimulus(2'b00, 4'b0000, 1'b0, 64'd1, 64'd2);
        #1;
        checkOutput("midflush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        validCount = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) validCount++;
            tick();
        end
        checkOutput("midflush_never_valid", validCount, 0);
        checkOutput("midflush_in_ready_after", in_ready, 1);

        runSingle("illegal_r", 2'b10, 4'b0011, 1'b0, 64'd10, 64'd20);
        checkOutput("illegal_r_flag", out_illegal, 1);
        checkOutput("illegal_r_result", out_result, 64'd30);
        checkOutput("illegal_r_op", out_op, 4'b0010);
        tick();
        runSingle("illegal_op11", 2'b11, 4'b0000, 1'b0, 64'd1, 64'd2);
        checkOutput("illegal_op11_flag", out_illegal, 1);
        tick();
        runSingle("legal_after", 2'b10, 4'b0000, 1'b0, 64'd40, 64'd2);
        checkOutput("legal_after_flag", out_illegal, 0);
        tick();
        tick();

        checkOutput("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
